// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: RV32I access-size encodings and load/store unit state type
package riscv_mem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic {IDLE, RMW_WR} lsu_state_t;
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: pipeline request side and word-only memory data port
interface load_store_unit_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
    logic              req_valid;
    logic              req_load;
    logic              req_store;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] store_data;
    logic              stall;
    logic [DATA_W-1:0] load_result;
    logic              load_valid;
    logic              misaligned;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;
    modport master (
        output req_valid, req_load, req_store, funct3, addr, store_data, mem_rdata,
        input  stall, load_result, load_valid, misaligned, mem_addr, mem_wdata, mem_read, mem_write
    );
    modport slave (
        input  req_valid, req_load, req_store, funct3, addr, store_data, mem_rdata,
        output stall, load_result, load_valid, misaligned, mem_addr, mem_wdata, mem_read, mem_write
    );
endinterface

// File: rtl/load_store_unit_load_extract.sv
// load_extract: select the addressed byte/halfword of a word and extend it
module load_extract
    import riscv_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);
    logic [7:0]  b;
    logic [15:0] h;
    assign b = 8'(word >> {offset, 3'b000});
    assign h = 16'(word >> {offset[1], 4'b0000});
    // Extension chosen by access size and signedness; LW passes through
    always_comb begin
        result = funct3 == F3_B  ? {{24{b[7]}}, b} :
                 funct3 == F3_H  ? {{16{h[15]}}, h} :
                 funct3 == F3_BU ? {24'd0, b} :
                 funct3 == F3_HU ? {16'd0, h} : word;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage byte/halfword/word access over a word-only memory port
module load_store_unit
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic clk,
    input logic reset,
    load_store_unit_if.slave bus
);
    lsu_state_t state, state_n;
    logic [DATA_W-1:0] merged, merged_n, lane, ext;
    logic [ADDR_W-1:0] word_addr, rmw_addr;
    logic [4:0] sh;
    logic is_load, is_store, legal, is_half, is_word, mis, idle, rmw, go, do_load, do_sw, do_sub;
    assign is_load   = bus.req_valid & bus.req_load & ~bus.req_store;
    assign is_store  = bus.req_valid & bus.req_store & ~bus.req_load;
    assign legal     = (is_load & (bus.funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})) |
                       (is_store & (bus.funct3 inside {F3_B, F3_H, F3_W}));
    assign is_half   = bus.funct3[1:0] == 2'b01;
    assign is_word   = bus.funct3[1:0] == 2'b10;
    assign mis       = (is_half & bus.addr[0]) | (is_word & |bus.addr[1:0]);
    assign idle      = state == IDLE && !reset;
    assign rmw       = state == RMW_WR && !reset;
    assign go        = idle & legal & ~mis;
    assign do_load   = go & is_load;
    assign do_sw     = go & is_store & is_word;
    assign do_sub    = go & is_store & ~is_word;
    assign word_addr = {bus.addr[ADDR_W-1:2], 2'b00};
    assign sh        = {bus.addr[1:0], 3'b000};
    assign lane      = (is_half ? DATA_W'(16'hFFFF) : DATA_W'(8'hFF)) << sh;
    assign merged_n  = (bus.mem_rdata & ~lane) | ((bus.store_data << sh) & lane);
    load_extract u_extract (
        .word   (bus.mem_rdata),
        .offset (bus.addr[1:0]),
        .funct3 (bus.funct3),
        .result (ext)
    );
    // Next state and memory-port controls; sub-word stores read first, write next cycle
    always_comb begin
        state_n       = do_sub ? RMW_WR : IDLE;
        bus.mem_read  = do_load | do_sub;
        bus.mem_write = do_sw | rmw;
        bus.stall     = do_sub;
        bus.mem_addr  = rmw ? rmw_addr : word_addr;
        bus.mem_wdata = rmw ? merged : do_sw ? bus.store_data : '0;
    end
    // State, registered load result/pulses, and the read-modify-write capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            bus.load_result <= '0;
            bus.load_valid  <= 1'b0;
            bus.misaligned  <= 1'b0;
            merged          <= '0;
            rmw_addr        <= '0;
        end else begin
            state          <= state_n;
            bus.load_valid <= do_load;
            bus.misaligned <= idle & legal & mis;
            if (do_load) bus.load_result <= ext;
            if (do_sub) begin
                merged   <= merged_n;
                rmw_addr <= word_addr;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed plan plus randomized requests against a byte-level memory model
module tb_load_store_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] mem [256] = '{default: '0};
    logic [31:0] ref_mem [256];
    load_store_unit_if bus ();
    load_store_unit dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;
    assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr[9:2]] : '0;
    // Word memory behind the data port
    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic run_op(input bit v, input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d);
        bit is_ld, is_st, legal, mis, go, sub, sw;
        int size, idx, off;
        logic [31:0] w, sv, exp_ld, nw;
        @(negedge clk);
        bus.req_valid = v; bus.req_load = ld; bus.req_store = st;
        bus.funct3 = f3; bus.addr = a; bus.store_data = d;
        is_ld = v && ld && !st;
        is_st = v && st && !ld;
        legal = (is_ld && f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (is_st && f3 inside {3'd0, 3'd1, 3'd2});
        size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        off = int'(a % 4);
        mis = legal && (a % size != 0);
        go = legal && !mis;
        sw = go && is_st && size == 4;
        sub = go && is_st && size != 4;
        idx = int'(a[9:2]);
        w = ref_mem[idx];
        sv = w >> (8 * off);
        case (f3)
            3'd0: exp_ld = 32'($signed(sv[7:0]));
            3'd1: exp_ld = 32'($signed(sv[15:0]));
            3'd4: exp_ld = {24'd0, sv[7:0]};
            3'd5: exp_ld = {16'd0, sv[15:0]};
            default: exp_ld = w;
        endcase
        nw = w;
        for (int i = 0; i < size; i++) nw[8*(off+i) +: 8] = d[8*i +: 8];
        #1;
        check("mem_read", bus.mem_read, go && (is_ld || sub));
        check("mem_write", bus.mem_write, sw);
        check("stall", bus.stall, sub);
        check("mem_wdata", bus.mem_wdata, sw ? d : 32'd0);
        if (go) check("mem_addr", bus.mem_addr, {a[31:2], 2'b00});
        @(posedge clk); #1;
        check("load_valid", bus.load_valid, go && is_ld);
        check("misaligned", bus.misaligned, mis);
        if (go && is_ld) check("load_result", bus.load_result, exp_ld);
        if (go && is_st) ref_mem[idx] = nw;
        if (sub) begin
            check("rmw_stall", bus.stall, 0);
            check("rmw_read", bus.mem_read, 0);
            check("rmw_write", bus.mem_write, 1);
            check("rmw_wdata", bus.mem_wdata, nw);
            check("rmw_addr", bus.mem_addr, {a[31:2], 2'b00});
            @(posedge clk); #1;
            check("post_rmw_valid", bus.load_valid, 0);
            check("post_rmw_mis", bus.misaligned, 0);
        end
        check("mem_word", mem[idx], ref_mem[idx]);
    endtask
    initial begin
        logic [2:0] f3;
        int kind;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        bus.req_valid = 1; bus.req_load = 1; bus.req_store = 0;
        bus.funct3 = 3'd2; bus.addr = 32'h100; bus.store_data = 32'h0;
        repeat (2) begin
            @(posedge clk); #1;
            check("rst_read", bus.mem_read, 0);
            check("rst_write", bus.mem_write, 0);
            check("rst_stall", bus.stall, 0);
            check("rst_valid", bus.load_valid, 0);
            check("rst_mis", bus.misaligned, 0);
            check("rst_result", bus.load_result, 0);
        end
        @(negedge clk);
        reset = 0; bus.req_valid = 0;
        run_op(1, 0, 1, 3'd2, 32'h100, 32'h8899AABB);
        run_op(1, 1, 0, 3'd0, 32'h103, 0);
        run_op(1, 1, 0, 3'd4, 32'h103, 0);
        run_op(1, 1, 0, 3'd1, 32'h102, 0);
        run_op(1, 1, 0, 3'd5, 32'h100, 0);
        run_op(1, 1, 0, 3'd2, 32'h100, 0);
        run_op(1, 0, 1, 3'd0, 32'h101, 32'h123456CC);
        check("plan_sb", mem[8'h40], 32'h8899CCBB);
        run_op(1, 1, 0, 3'd2, 32'h100, 0);
        run_op(1, 0, 1, 3'd1, 32'h102, 32'h0000BEEF);
        check("plan_sh", mem[8'h40], 32'hBEEFCCBB);
        run_op(1, 0, 1, 3'd2, 32'h104, 32'hDEADBEEF);
        check("plan_sw", mem[8'h41], 32'hDEADBEEF);
        run_op(1, 1, 0, 3'd2, 32'h102, 0);
        run_op(1, 0, 1, 3'd1, 32'h103, 32'h1111);
        run_op(1, 1, 1, 3'd2, 32'h100, 0);
        run_op(1, 0, 1, 3'd4, 32'h100, 32'h55);
        run_op(0, 1, 0, 3'd2, 32'h100, 0);
        @(negedge clk);
        bus.req_valid = 1; bus.req_load = 0; bus.req_store = 1;
        bus.funct3 = 3'd0; bus.addr = 32'h100; bus.store_data = 32'h77;
        #1 check("rst_rmw_stall", bus.stall, 1);
        @(negedge clk);
        reset = 1;
        #1 check("rst_rmw_write", bus.mem_write, 0);
        @(posedge clk); #1;
        check("rst_rmw_mem", mem[8'h40], 32'hBEEFCCBB);
        check("rst_rmw_valid", bus.load_valid, 0);
        check("rst_rmw_mis", bus.misaligned, 0);
        check("rst_rmw_result", bus.load_result, 0);
        check("rst_rmw_read", bus.mem_read, 0);
        @(negedge clk);
        reset = 0; bus.req_valid = 0;
        @(posedge clk); #1;
        check("idle_write", bus.mem_write, 0);
        run_op(1, 1, 0, 3'd2, 32'h100, 0);
        for (int n = 0; n < 400; n++) begin
            kind = int'($urandom_range(0, 9));
            f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) | (($urandom_range(0, 1) != 0) ? 3'd4 : 3'd0)
                                             : 3'($urandom);
            run_op($urandom_range(0, 15) != 0,
                   kind < 5 || kind == 9 ? 1'b1 : 1'b0,
                   kind >= 5 ? 1'b1 : 1'b0,
                   f3, 32'h100 + 32'($urandom_range(0, 255)), $urandom);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
